// File: rtl/pushsw_pkg.sv
// rtl/pushsw_pkg.sv - shared state encoding, default timing and direction indices
package pushsw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS_DB = 3'd1,
        ST_HELD     = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_REL_DB   = 3'd4
    } pushsw_state_e;

    localparam int DEB_CYCLES_DEF    = 500000;
    localparam int REPEAT_DELAY_DEF  = 25000000;
    localparam int REPEAT_PERIOD_DEF = 5000000;
    localparam int TMR_W_DEF         = 25;

    localparam int UP_IDX = 1;
    localparam int DN_IDX = 0;

endpackage

// File: rtl/pushsw_channel.sv
// rtl/pushsw_channel.sv - synchroniser, debounce and auto-repeat FSM for one push switch
module pushsw_channel
    import pushsw_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter int REPEAT_EN     = 1,
    parameter int TMR_W         = TMR_W_DEF
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic push_n_i,
    output logic evt_o
);

    // The IDLE cycle that first sees s=1 is the first of the DEB_CYCLES stable samples.
    localparam logic [TMR_W-1:0] DEB_LAST = TMR_W'((DEB_CYCLES >= 2) ? DEB_CYCLES - 2 : 0);
    localparam logic [TMR_W-1:0] RD_LAST  = TMR_W'((REPEAT_DELAY >= 1) ? REPEAT_DELAY - 1 : 0);
    localparam logic [TMR_W-1:0] RP_LAST  = TMR_W'((REPEAT_PERIOD >= 1) ? REPEAT_PERIOD - 1 : 0);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    logic             sync1_q, sync2_q, s;
    pushsw_state_e    state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d, rpt_q, rpt_d;
    logic             armed_q, armed_d, from_rpt_q, from_rpt_d;
    logic             evt_q, fire;

    assign s     = ~sync2_q;
    assign evt_o = evt_q;

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        rpt_d      = rpt_q;
        armed_d    = armed_q;
        from_rpt_d = from_rpt_q;
        fire       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // After reset the button must be seen released before it may fire.
                if (!armed_q) begin
                    if (s)                    tmr_d = '0;
                    else if (tmr_q >= DEB_LAST) armed_d = 1'b1;
                    else                      tmr_d = tmr_q + TMR_ONE;
                end else if (s) begin
                    state_d = ST_PRESS_DB;
                    tmr_d   = '0;
                end
            end
            ST_PRESS_DB: begin
                if (!s) begin
                    state_d = ST_IDLE;
                end else if (tmr_q >= DEB_LAST) begin
                    state_d = ST_HELD;
                    fire    = 1'b1;
                    tmr_d   = '0;
                    rpt_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            ST_HELD, ST_REPEAT: begin
                if (!s) begin
                    state_d    = ST_REL_DB;
                    tmr_d      = '0;
                    from_rpt_d = (state_q == ST_REPEAT);
                end else if (REPEAT_EN != 0) begin
                    if (rpt_q >= ((state_q == ST_HELD) ? RD_LAST : RP_LAST)) begin
                        state_d = ST_REPEAT;
                        fire    = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_q + TMR_ONE;
                    end
                end
            end
            ST_REL_DB: begin
                // rpt_q is left untouched here so a bounce resumes the repeat schedule.
                if (s)                      state_d = from_rpt_q ? ST_REPEAT : ST_HELD;
                else if (tmr_q >= DEB_LAST) state_d = ST_IDLE;
                else                        tmr_d   = tmr_q + TMR_ONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            rpt_q      <= '0;
            armed_q    <= 1'b0;
            from_rpt_q <= 1'b0;
            evt_q      <= 1'b0;
        end else begin
            sync1_q    <= push_n_i;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            rpt_q      <= rpt_d;
            armed_q    <= armed_d;
            from_rpt_q <= from_rpt_d;
            evt_q      <= fire;
        end
    end

endmodule

// File: rtl/pushsw_count_ctrl.sv
// rtl/pushsw_count_ctrl.sv - up/down push-switch arbiter driving the shared wrapping counter
module pushsw_count_ctrl
    import pushsw_pkg::*;
#(
    parameter int WIDTH         = 10,
    parameter int MAX_COUNT     = 255,
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter int REPEAT_EN     = 1,
    parameter int TMR_W         = TMR_W_DEF
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [1:0]       PUSH,
    output logic [WIDTH-1:0] COUNT,
    output logic [9:0]       LEDout,
    output logic             UP_EVT,
    output logic             DN_EVT,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    pushsw_channel #(
        .DEB_CYCLES(DEB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
        .REPEAT_EN(REPEAT_EN), .TMR_W(TMR_W)
    ) u_up (
        .clk_i(CLK), .rstn_i(RSTn), .push_n_i(PUSH[UP_IDX]), .evt_o(UP_EVT)
    );

    pushsw_channel #(
        .DEB_CYCLES(DEB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
        .REPEAT_EN(REPEAT_EN), .TMR_W(TMR_W)
    ) u_dn (
        .clk_i(CLK), .rstn_i(RSTn), .push_n_i(PUSH[DN_IDX]), .evt_o(DN_EVT)
    );

    // Simultaneous up and down cancel; neither request is queued.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (UP_EVT && !DN_EVT) begin
            if (count_q == MAXV) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + ONE;
            end
        end else if (DN_EVT && !UP_EVT) begin
            if (count_q == '0) begin
                count_d = MAXV;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign COUNT = count_q;
    assign WRAP  = wrap_q;

    generate
        if (WIDTH >= 10) begin : g_led_trunc
            assign LEDout = count_q[9:0];
        end else begin : g_led_ext
            assign LEDout = {{(10 - WIDTH){1'b0}}, count_q};
        end
    endgenerate

endmodule

// File: tb/tb_pushsw_count_ctrl.sv
// tb/tb_pushsw_count_ctrl.sv - directed self-checking bench for pushsw_count_ctrl
module tb_pushsw_count_ctrl;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic [1:0] PUSH;
    logic [9:0] COUNT, LEDout, COUNT_nr, LEDout_nr;
    logic       UP_EVT, DN_EVT, WRAP, UP_EVT_nr, DN_EVT_nr, WRAP_nr;

    int checks = 0;
    int errors = 0;
    int up_n   = 0;
    int dn_n   = 0;
    int up_s, dn_s, nr_s;

    always #5 CLK = ~CLK;

    pushsw_count_ctrl #(
        .WIDTH(10), .MAX_COUNT(255), .DEB_CYCLES(4), .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8), .REPEAT_EN(1), .TMR_W(8)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .PUSH(PUSH), .COUNT(COUNT), .LEDout(LEDout),
        .UP_EVT(UP_EVT), .DN_EVT(DN_EVT), .WRAP(WRAP)
    );

    pushsw_count_ctrl #(
        .WIDTH(10), .MAX_COUNT(255), .DEB_CYCLES(4), .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8), .REPEAT_EN(0), .TMR_W(8)
    ) dut_nr (
        .CLK(CLK), .RSTn(RSTn), .PUSH(PUSH), .COUNT(COUNT_nr), .LEDout(LEDout_nr),
        .UP_EVT(UP_EVT_nr), .DN_EVT(DN_EVT_nr), .WRAP(WRAP_nr)
    );

    always @(negedge CLK) begin
        if (UP_EVT) up_n++;
        if (DN_EVT) dn_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Press one or both buttons, return at the negedge after COUNT has reacted to the event.
    task automatic press(input logic [1:0] mask, input string tag);
        bit seen = 0;
        @(negedge CLK);
        PUSH = PUSH & ~mask;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge CLK);
            if (UP_EVT || DN_EVT) seen = 1;
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
        @(negedge CLK);
    endtask

    task automatic release_all();
        PUSH = 2'b11;
        repeat (12) @(negedge CLK);
    endtask

    initial begin
        RSTn = 1'b0;
        PUSH = 2'b11;
        repeat (2) @(negedge CLK);
        chk("reset_count", COUNT, 0);
        chk("reset_up_evt", UP_EVT, 0);
        chk("reset_wrap", WRAP, 0);
        RSTn = 1'b1;
        repeat (10) @(negedge CLK);

        // Bounce shorter than debounce window
        PUSH[1] = 1'b0;
        repeat (3) @(negedge CLK);
        PUSH[1] = 1'b1;
        repeat (12) @(negedge CLK);
        chk("bounce_no_evt", up_n, 0);
        chk("bounce_count", COUNT, 0);

        // Press latency: PUSH falls before edge 0
        PUSH[1] = 1'b0;
        repeat (5) @(negedge CLK);
        chk("lat_evt_edge4", UP_EVT, 0);
        @(negedge CLK);
        chk("lat_evt_edge5", UP_EVT, 1);
        chk("lat_count_edge5", COUNT, 0);
        @(negedge CLK);
        chk("lat_count_edge6", COUNT, 1);
        chk("lat_evt_edge6", UP_EVT, 0);
        release_all();

        press(2'b01, "dn1");
        chk("dn_1_to_0", COUNT, 0);
        chk("dn_1_to_0_wrap", WRAP, 0);
        release_all();
        press(2'b01, "dn0");
        chk("wrap_dn_count", COUNT, 255);
        chk("wrap_dn_pulse", WRAP, 1);
        @(negedge CLK);
        chk("wrap_dn_pulse_end", WRAP, 0);
        release_all();
        press(2'b10, "up255");
        chk("wrap_up_count", COUNT, 0);
        chk("wrap_up_pulse", WRAP, 1);
        release_all();

        // Auto-repeat: events at offsets 0,20,28,36,44,52 then release
        up_s = up_n;
        nr_s = int'(COUNT_nr);
        press(2'b10, "rpt");
        repeat (54) @(negedge CLK);
        release_all();
        chk("rpt_events", up_n - up_s, 6);
        chk("rpt_count", COUNT, 6);
        chk("rpt_dis_count", COUNT_nr, (nr_s + 1) % 256);

        repeat (4) begin
            press(2'b10, "up_to10");
            release_all();
        end
        chk("pre_sim_count", COUNT, 10);

        // Simultaneous up and down
        @(negedge CLK);
        PUSH = 2'b00;
        repeat (6) @(negedge CLK);
        chk("sim_up_evt", UP_EVT, 1);
        chk("sim_dn_evt", DN_EVT, 1);
        @(negedge CLK);
        chk("sim_count", COUNT, 10);
        chk("sim_wrap", WRAP, 0);
        release_all();

        // Hold up until 37
        PUSH[1] = 1'b0;
        for (int i = 0; i < 400 && COUNT != 10'd37; i++) @(negedge CLK);
        release_all();
        chk("hold_to_37", COUNT, 37);
        chk("led_37", LEDout, 37);

        // RSTn pulse between edges has no effect
        #1 RSTn = 1'b0;
        #2 RSTn = 1'b1;
        @(negedge CLK);
        chk("glitch_rst_count", COUNT, 37);

        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        chk("rst_mid_count", COUNT, 0);
        chk("rst_mid_up", UP_EVT, 0);
        chk("rst_mid_dn", DN_EVT, 0);
        chk("rst_mid_wrap", WRAP, 0);
        repeat (10) @(negedge CLK);

        // Reset while held: button must be released and re-pressed
        press(2'b01, "held_dn");
        chk("held_dn_count", COUNT, 255);
        repeat (3) @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        dn_s = dn_n;
        repeat (40) @(negedge CLK);
        chk("held_rst_no_evt", dn_n - dn_s, 0);
        chk("held_rst_count", COUNT, 0);
        release_all();
        press(2'b01, "repress_dn");
        chk("repress_evts", dn_n - dn_s, 1);
        chk("repress_count", COUNT, 255);
        chk("repress_wrap", WRAP, 1);
        release_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
